// File: rtl/fpga_host_uart_system_if.sv
// Board-side signal bundle of the UART loopback host: serial pins, the
// finish-packet request and the status outputs.
interface fpga_host_uart_system_if;
  logic rx_i;
  logic tx_o;
  logic send_i;
  logic error_o;
  logic reset_o;

  // Host/board side drives the serial input and the send request.
  modport master (
    output rx_i,
    output send_i,
    input  tx_o,
    input  error_o,
    input  reset_o
  );

  // The loopback block itself.
  modport slave (
    input  rx_i,
    input  send_i,
    output tx_o,
    output error_o,
    output reset_o
  );
endinterface

// File: rtl/fpga_host_uart_system.sv
// UART NBF loopback: receives 14-byte NBF packets on rx, buffers them in an
// input FIFO, moves them to an output FIFO and re-serializes them on tx.
// send_i injects a finish packet; error_o is a sticky fault flag.
module fpga_host_uart_system #(
  parameter int nbf_addr_width_p        = 40,
  parameter int nbf_data_width_p        = 64,
  parameter int uart_clk_per_bit_p      = 10416,
  parameter int uart_data_bits_p        = 8,
  parameter int uart_parity_bit_p       = 0,
  parameter int uart_parity_odd_p       = 0,
  parameter int uart_stop_bits_p        = 1,
  parameter int io_in_nbf_buffer_els_p  = 4,
  parameter int io_out_nbf_buffer_els_p = 4
) (
  input logic                    sys_clk_i,
  input logic                    reset_i,
  fpga_host_uart_system_if.slave io
);

  localparam int PKT_W     = 8 + nbf_addr_width_p + nbf_data_width_p;
  localparam int PKT_BYTES = PKT_W / 8;
  localparam int BYTE_CW   = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int CNT_W     = (uart_clk_per_bit_p > 1) ? $clog2(uart_clk_per_bit_p) : 1;
  localparam int IN_AW     = (io_in_nbf_buffer_els_p > 1) ? $clog2(io_in_nbf_buffer_els_p) : 1;
  localparam int IN_CW     = $clog2(io_in_nbf_buffer_els_p + 1);
  localparam int OUT_AW    = (io_out_nbf_buffer_els_p > 1) ? $clog2(io_out_nbf_buffer_els_p) : 1;
  localparam int OUT_CW    = $clog2(io_out_nbf_buffer_els_p + 1);

  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(uart_clk_per_bit_p - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(uart_clk_per_bit_p / 2 - 1);
  localparam logic [3:0]         DBIT_LAST = 4'(uart_data_bits_p - 1);
  localparam logic [3:0]         STOP_LAST = 4'(uart_stop_bits_p - 1);
  localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(PKT_BYTES - 1);
  localparam logic [8:0]         DATA_MASK = 9'((1 << uart_data_bits_p) - 1);
  localparam logic               PAR_EN    = (uart_parity_bit_p != 0);
  localparam logic               PAR_ODD   = (uart_parity_odd_p != 0);
  localparam logic [IN_CW-1:0]   IN_FULL   = IN_CW'(io_in_nbf_buffer_els_p);
  localparam logic [IN_AW-1:0]   IN_LAST   = IN_AW'(io_in_nbf_buffer_els_p - 1);
  localparam logic [OUT_CW-1:0]  OUT_FULL  = OUT_CW'(io_out_nbf_buffer_els_p);
  localparam logic [OUT_AW-1:0]  OUT_LAST  = OUT_AW'(io_out_nbf_buffer_els_p - 1);

  typedef logic [PKT_BYTES-1:0][7:0] pkt_t;
  localparam pkt_t FINISH_PKT = pkt_t'({{(PKT_W - 8){1'b0}}, 8'hFF});

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  // Parity bit value that goes with a data word (only the configured data bits count).
  function automatic logic parity_of(input logic [8:0] d);
    return (^(d & DATA_MASK)) ^ PAR_ODD;
  endfunction

  // Receiver state
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [8:0]       rx_shift_q, rx_shift_d;
  logic             rx_par_q, rx_par_d;
  logic             rx_valid, rx_err;

  // Packet assembly and FIFOs
  pkt_t               pkt_q, pkt_d;
  logic [BYTE_CW-1:0] sipo_cnt_q, sipo_cnt_d, piso_cnt_q, piso_cnt_d;
  pkt_t               in_mem_q [io_in_nbf_buffer_els_p];
  pkt_t               out_mem_q [io_out_nbf_buffer_els_p];
  logic [IN_AW-1:0]   in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [IN_CW-1:0]   in_cnt_q, in_cnt_d;
  logic [OUT_AW-1:0]  out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [OUT_CW-1:0]  out_cnt_q, out_cnt_d;
  logic               in_push_req, in_push, in_pop, in_drop, in_we;
  logic               out_push, out_pop, out_we, send_drop;
  pkt_t               in_wdata, out_wdata;

  // Transmitter state
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             tx_par_q, tx_par_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_valid, tx_ready;
  logic [7:0]       tx_byte;

  logic error_q, error_d, rst_out_q, rst_out_d;

  assign tx_ready = (tx_state_q == TX_IDLE);

  // Receiver: input synchronizer, start-edge detect, mid-bit sampling, frame checks.
  always_comb begin
    rx_s1_d    = io.rx_i;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_valid   = 1'b0;
    rx_err     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // A falling edge, not a low level, starts a frame, so a line still
        // low after a bad stop bit cannot launch a bogus frame.
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_shift_d = {1'b0, rx_shift_q[8:1]};
          rx_shift_d[uart_data_bits_p-1] = rx_s2_q;
          if (rx_bit_q == DBIT_LAST) begin
            rx_bit_d   = '0;
            rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s2_q;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (!rx_s2_q) begin
            rx_err     = 1'b1;
            rx_state_d = RX_IDLE;
          end else if (rx_bit_q == STOP_LAST) begin
            rx_state_d = RX_IDLE;
            if (PAR_EN && (parity_of(rx_shift_q) != rx_par_q)) rx_err = 1'b1;
            else rx_valid = 1'b1;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Packet assembly, input/output FIFOs, loopback move, send_i injection and byte feed to TX.
  always_comb begin
    pkt_d       = pkt_q;
    sipo_cnt_d  = sipo_cnt_q;
    in_push_req = 1'b0;
    if (rx_valid) begin
      pkt_d[sipo_cnt_q] = rx_shift_q[7:0];
      if (sipo_cnt_q == BYTE_LAST) begin
        sipo_cnt_d  = '0;
        in_push_req = 1'b1;
      end else begin
        sipo_cnt_d = sipo_cnt_q + 1'b1;
      end
    end

    tx_valid   = (out_cnt_q != '0);
    tx_byte    = out_mem_q[out_rptr_q][piso_cnt_q];
    piso_cnt_d = piso_cnt_q;
    out_pop    = 1'b0;
    if (tx_valid && tx_ready) begin
      if (piso_cnt_q == BYTE_LAST) begin
        piso_cnt_d = '0;
        out_pop    = 1'b1;
      end else begin
        piso_cnt_d = piso_cnt_q + 1'b1;
      end
    end

    // A finish request wins the out-FIFO write port over the loopback move.
    out_push  = 1'b0;
    out_wdata = FINISH_PKT;
    in_pop    = 1'b0;
    send_drop = 1'b0;
    if (io.send_i) begin
      if ((out_cnt_q != OUT_FULL) || out_pop) out_push = 1'b1;
      else send_drop = 1'b1;
    end else if ((in_cnt_q != '0) && (out_cnt_q != OUT_FULL)) begin
      in_pop    = 1'b1;
      out_push  = 1'b1;
      out_wdata = in_mem_q[in_rptr_q];
    end

    in_push  = in_push_req && ((in_cnt_q != IN_FULL) || in_pop);
    in_drop  = in_push_req && !in_push;
    in_we    = in_push;
    in_wdata = pkt_d;
    out_we   = out_push;

    in_wptr_d = in_push ? ((in_wptr_q == IN_LAST) ? '0 : in_wptr_q + 1'b1) : in_wptr_q;
    in_rptr_d = in_pop  ? ((in_rptr_q == IN_LAST) ? '0 : in_rptr_q + 1'b1) : in_rptr_q;
    in_cnt_d  = in_cnt_q;
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + 1'b1;
      2'b01:   in_cnt_d = in_cnt_q - 1'b1;
      default: in_cnt_d = in_cnt_q;
    endcase

    out_wptr_d = out_push ? ((out_wptr_q == OUT_LAST) ? '0 : out_wptr_q + 1'b1) : out_wptr_q;
    out_rptr_d = out_pop  ? ((out_rptr_q == OUT_LAST) ? '0 : out_rptr_q + 1'b1) : out_rptr_q;
    out_cnt_d  = out_cnt_q;
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase

    error_d   = error_q | rx_err | in_drop | send_drop;
    rst_out_d = reset_i;
  end

  // Transmitter: accepts a byte only in idle, then walks start/data/parity/stop bit slots.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_byte};
          tx_par_d   = parity_of({1'b0, tx_byte});
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[8:1]};
          if (tx_bit_q == DBIT_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
          else tx_bit_d = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_d[0];
      TX_PARITY: tx_line_d = tx_par_d;
      default:   tx_line_d = 1'b1;
    endcase
  end

  // Control registers: state machines, counters, pointers, flags.
  always_ff @(posedge sys_clk_i) begin
    rst_out_q <= rst_out_d;
    if (reset_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      sipo_cnt_q <= '0;
      piso_cnt_q <= '0;
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_cnt_q   <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      sipo_cnt_q <= sipo_cnt_d;
      piso_cnt_q <= piso_cnt_d;
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      in_cnt_q   <= in_cnt_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_cnt_q  <= out_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
      error_q    <= error_d;
    end
  end

  // Data registers: shift registers, packet assembly and FIFO storage carry no reset.
  always_ff @(posedge sys_clk_i) begin
    rx_shift_q <= rx_shift_d;
    rx_par_q   <= rx_par_d;
    tx_shift_q <= tx_shift_d;
    tx_par_q   <= tx_par_d;
    pkt_q      <= pkt_d;
    if (in_we) in_mem_q[in_wptr_q] <= in_wdata;
    if (out_we) out_mem_q[out_wptr_q] <= out_wdata;
  end

  assign io.tx_o    = tx_line_q;
  assign io.error_o = error_q;
  assign io.reset_o = rst_out_q;

endmodule

// File: tb/tb_fpga_host_uart_system.sv
// Bench for the UART NBF loopback: drives UART frames on rx, decodes tx frames,
// and compares the echoed byte stream with an expected-byte queue.
module tb_fpga_host_uart_system;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] last_bytes [14];
  logic [7:0] mon_b;

  fpga_host_uart_system_if ifc ();

  fpga_host_uart_system #(.uart_clk_per_bit_p(CPB)) dut (
    .sys_clk_i (clk),
    .reset_i   (rst),
    .io        (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [39:0] addr;
    logic [63:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b13;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One UART frame, 8N1, LSB first; stop_val=0 produces a framing error.
  task automatic uart_send_byte(input logic [7:0] b, input logic stop_val);
    @(negedge clk);
    ifc.rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ifc.rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    ifc.rx_i = stop_val;
    repeat (CPB) @(negedge clk);
    ifc.rx_i = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [39:0] a, input logic [63:0] d,
                          input int nbytes);
    logic [111:0] p;
    p = {d, a, op};
    for (int k = 0; k < nbytes; k++) uart_send_byte(p[8*k +: 8], 1'b1);
  endtask

  // Reference: a packet is echoed as its own 14 bytes, byte k = packet bits [8k+7:8k].
  task automatic model_pkt(input logic [7:0] op, input logic [39:0] a, input logic [63:0] d);
    logic [111:0] p;
    p = {d, a, op};
    for (int k = 0; k < 14; k++) exp_q.push_back(p[8*k +: 8]);
  endtask

  task automatic check_echo(input string nm);
    int n;
    int waited;
    logic [7:0] g;
    logic [7:0] e;
    n = exp_q.size();
    waited = 0;
    while (got_q.size() < n && waited < n * CPB * 14 + 4000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (got_q.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: got %0d bytes expected %0d", nm, got_q.size(), n);
      exp_q.delete();
      got_q.delete();
    end else begin
      for (int i = 0; i < n; i++) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        last_bytes[i % 14] = g;
        chk($sformatf("%s_byte%0d", nm, i), {56'd0, g}, {56'd0, e});
      end
    end
  endtask

  // TX line decoder: start detect, mid-bit sampling, stop-bit check.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ifc.tx_o === 1'b0) begin
        repeat (CPB + CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          mon_b[i] = ifc.tx_o;
          repeat (CPB) @(negedge clk);
        end
        chk("tx_stop_bit", {63'd0, ifc.tx_o}, 64'd1);
        got_q.push_back(mon_b);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [3];
    logic [7:0]  rop;
    logic [39:0] raddr;
    logic [63:0] rdata;

    vecs[0] = '{"finish", 8'hFF, 40'h0, 64'h0, 8'hFF, 8'h00, 8'h00};
    vecs[1] = '{"fields", 8'h01, 40'h12_3456_789A, 64'hDEAD_BEEF_0123_4567, 8'h01, 8'h9A, 8'hDE};
    vecs[2] = '{"fields2", 8'h5A, 40'h01_0203_0405, 64'h8877_6655_4433_2211, 8'h5A, 8'h05, 8'h88};

    ifc.rx_i   = 1'b1;
    ifc.send_i = 1'b0;
    rst        = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_tx", {63'd0, ifc.tx_o}, 64'd1);
    chk("reset_error", {63'd0, ifc.error_o}, 64'd0);
    chk("reset_reset_o", {63'd0, ifc.reset_o}, 64'd1);
    rst = 1'b0;
    #1;
    chk("reset_o_still_high", {63'd0, ifc.reset_o}, 64'd1);
    @(negedge clk);
    chk("reset_o_fell", {63'd0, ifc.reset_o}, 64'd0);
    repeat (4) @(negedge clk);

    // Table-driven single packets
    for (int v = 0; v < 3; v++) begin
      model_pkt(vecs[v].op, vecs[v].addr, vecs[v].data);
      send_pkt(vecs[v].op, vecs[v].addr, vecs[v].data, 14);
      check_echo(vecs[v].name);
      chk({vecs[v].name, "_b0"}, {56'd0, last_bytes[0]}, {56'd0, vecs[v].b0});
      chk({vecs[v].name, "_b1"}, {56'd0, last_bytes[1]}, {56'd0, vecs[v].b1});
      chk({vecs[v].name, "_b13"}, {56'd0, last_bytes[13]}, {56'd0, vecs[v].b13});
    end
    chk("error_after_finish", {63'd0, ifc.error_o}, 64'd0);

    // Two finish packets back to back
    model_pkt(8'hFF, 40'h0, 64'h0);
    model_pkt(8'hFF, 40'h0, 64'h0);
    send_pkt(8'hFF, 40'h0, 64'h0, 14);
    send_pkt(8'hFF, 40'h0, 64'h0, 14);
    check_echo("back2back");

    // Random packets, sent without gaps
    for (int r = 0; r < 4; r++) begin
      rop   = 8'($urandom);
      raddr = {8'($urandom), 32'($urandom)};
      rdata = {32'($urandom), 32'($urandom)};
      model_pkt(rop, raddr, rdata);
      send_pkt(rop, raddr, rdata, 14);
    end
    check_echo("random");

    // send_i pulse while idle
    @(negedge clk);
    ifc.send_i = 1'b1;
    @(negedge clk);
    ifc.send_i = 1'b0;
    model_pkt(8'hFF, 40'h0, 64'h0);
    check_echo("send_pulse");
    chk("error_still_clear", {63'd0, ifc.error_o}, 64'd0);

    // Reset after byte 6 of a packet
    send_pkt(8'h77, 40'hAB_CDEF_0123, 64'h1122_3344_5566_7788, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_reset_o_high", {63'd0, ifc.reset_o}, 64'd1);
    chk("midreset_tx_idle", {63'd0, ifc.tx_o}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_reset_o_lag", {63'd0, ifc.reset_o}, 64'd1);
    @(negedge clk);
    chk("midreset_reset_o_low", {63'd0, ifc.reset_o}, 64'd0);
    repeat (30 * CPB) @(negedge clk);
    chk("midreset_no_echo", 64'(got_q.size()), 64'd0);
    model_pkt(8'h42, 40'h99_8877_6655, 64'hCAFE_F00D_0BAD_BEEF);
    send_pkt(8'h42, 40'h99_8877_6655, 64'hCAFE_F00D_0BAD_BEEF, 14);
    check_echo("after_reset");

    // Framing error: byte dropped, error sticky until reset
    chk("pre_frame_error", {63'd0, ifc.error_o}, 64'd0);
    uart_send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("frame_error_set", {63'd0, ifc.error_o}, 64'd1);
    model_pkt(8'h3C, 40'hA1_B2C3_D4E5, 64'h0F1E_2D3C_4B5A_6978);
    send_pkt(8'h3C, 40'hA1_B2C3_D4E5, 64'h0F1E_2D3C_4B5A_6978, 14);
    check_echo("after_frame_error");
    chk("frame_error_sticky", {63'd0, ifc.error_o}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("error_cleared_by_reset", {63'd0, ifc.error_o}, 64'd0);
    repeat (20 * CPB) @(negedge clk);
    chk("no_extra_bytes", 64'(got_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpga_host_uart_system.md
# fpga_host_uart_system

UART-attached FPGA host loopback block. It deserializes NBF (network boot format) packets arriving on a UART RX line and buffers them. Each packet is re-serialized unchanged onto the UART TX line. It sits between the board UART pins and the host-side NBF datapath, and contains its own UART receiver and transmitter. It also drives a reset output and a sticky error flag.

## Interface
- nbf_addr_width_p, 40: NBF address field width.
- nbf_data_width_p, 64: NBF data field width. Packet width is 8+addr+data = 112 bits = 14 bytes (must be a multiple of 8).
- uart_clk_per_bit_p, 10416: clocks per UART bit (100 MHz / 9600 baud).
- uart_data_bits_p, 8: data bits per UART frame (5-9; only 8 is used for NBF).
- uart_parity_bit_p, 0: 1 enables a parity bit.
- uart_parity_odd_p, 0: 0 selects even parity, 1 selects odd parity.
- uart_stop_bits_p, 1: stop bits per frame (1 or 2).
- io_in_nbf_buffer_els_p, 4: depth of the received-packet FIFO, in packets.
- io_out_nbf_buffer_els_p, 4: depth of the transmit-packet FIFO, in packets.
- sys_clk_i  in  1  sole clock; all logic is on its rising edge.
- reset_i  in  1  reset; synchronous, active-high.
- rx_i  in  1  UART serial input; idle is high.
- tx_o  out  1  UART serial output; idle is high.
- send_i  in  1  one-cycle pulse that injects a finish packet into the TX path.
- error_o  out  1  sticky error flag.
- reset_o  out  1  reset output to the downstream core.

## Operation
- **UART frame:** start bit (0), data bits LSB first, optional parity bit, then stop bit(s) (1).
- **RX timing:** the receiver detects the falling edge of the start bit. It re-checks the line at half a bit period and aborts the frame if the line is high. It then samples every uart_clk_per_bit_p clocks at mid-bit.
- **RX errors:**
  - A stop bit sampled low, or a parity mismatch, causes the byte to be discarded and error_o to be set.
  - The receiver then returns to idle.
- **SIPO:** received bytes fill a 14-byte packet register LSB-first. Byte k maps to packet bits [8k+7:8k].
- **Packet fields:** bits [7:0] are the opcode, [47:8] the address, [111:48] the data. The finish opcode is 8'hFF.
- **Packet completion:** after byte 13, the packet is pushed into the in-FIFO. If the in-FIFO is full, the packet is dropped and error_o is set.
- **Loopback:** the in-FIFO head moves to the out-FIFO whenever the out-FIFO has space. Every opcode is passed through unmodified.
- **send_i:** enqueues a packet with opcode 8'hFF, address 0 and data 0 into the out-FIFO. It has priority over loopback in the same cycle. If the out-FIFO is full, the request is dropped and error_o is set.
- **PISO:** the out-FIFO head is sent as 14 UART frames, byte 0 first. The entry pops once byte 13 has been handed to the transmitter.
- **TX:** the transmitter accepts a byte via a valid/ready handshake, only while idle. It drives start, data, parity and stop bits, each held for uart_clk_per_bit_p clocks.
- **error_o:** sticky; cleared only by reset_i.
- **reset_o:** a registered copy of reset_i.

## Timing
- **Reset values:**
  - tx_o = 1, error_o = 0, reset_o = 1.
  - FIFOs empty, SIPO/PISO byte counters = 0.
  - UART state machines idle, bit counters = 0.
- **reset_o** falls on the first clock edge after reset_i is sampled low.
- **Reset mid-operation:** any partial packet or frame is discarded. tx_o returns to 1 on the next edge.
- **RX state machine:** IDLE -> START -> DATA(n) -> [PARITY] -> STOP(1..2) -> IDLE.
  - The RX valid pulse is one cycle, at the mid-point sample of the last stop bit.
- **TX state machine:** IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Ready is high only in IDLE. A byte is accepted on a cycle where valid and ready are both high.
  - The start bit appears on tx_o the cycle after acceptance.
- **Echo latency:**
  - The first echoed start bit begins at most 8 clocks after the RX valid pulse of received byte 13.
  - Consecutive TX frames are separated by at most 2 idle clocks.
- **Simultaneous push and pop on a full FIFO:** permitted (the pop frees the slot).
- **Counters:** the bit counter must hold at least uart_clk_per_bit_p-1 (clog2 width). The byte counter wraps 13 -> 0.

## Test plan
- **Finish echo:** after reset, send a finish packet (opcode FF, address 0, data 0) at 9600 baud on a 100 MHz clock -> 14 bytes returned on tx_o equal the input bytes; error_o stays 0.
- **Back-to-back packets:** send 2 finish packets back-to-back -> both echoed in order, identical to the input.
- **Field ordering:** send opcode 01, address 40'h12_3456_789A, data 64'hDEAD_BEEF_0123_4567 -> byte 0 = 01, byte 1 = 9A, byte 13 = DE on tx_o.
- **Framing error:** drive a frame with its stop bit low -> error_o = 1 from the next cycle, that byte is dropped, and error_o stays 1 until reset.
- **send_i pulse:** pulse send_i for one cycle while idle -> 14 bytes FF,00,...,00 appear on tx_o.
- **Reset mid-packet:** assert reset_i after byte 6 of a packet -> no echo occurs. The next full packet is echoed correctly and reset_o follows reset_i one cycle late.
